cc_bin2bcd_scheduler: RTL and testbench

- Sequential, shared binary-to-BCD converter with a round-robin arbiter for up to NREQ requesters (score, speed, fuel counters in the game datapath).
- Each requester presents an 8-bit value and holds a request. The block:
  - grants one requester;
  - runs double-dabble one shift per clock;
  - writes a 3-digit BCD result into that requester's output slot;
  - acknowledges the request.
- It sits between the game counters and the 7-segment/display drivers, replacing per-counter combinational converters.

---
 rtl/cc_bin2bcd_pkg.sv | 20 ++
 rtl/cc_bcd_dabble_step.sv | 24 ++
 rtl/cc_bin2bcd_scheduler.sv | 144 ++++++++++++++
 tb/tb_cc_bin2bcd_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_bin2bcd_pkg.sv
// Shared types and constants for the time-multiplexed binary-to-BCD converter.
package cc_bin2bcd_pkg;

  localparam int BIN_W          = 8;
  localparam int BCD_W          = 12;
  localparam int DIGIT_W        = 4;
  localparam int ITER           = 8;
  localparam int ADD3_THRESHOLD = 4;

  // The BCD field sits above the binary field so each shift carries one binary bit into the units digit.
  localparam int SR_W    = BCD_W + BIN_W;
  localparam int NDIGITS = BCD_W / DIGIT_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } schedState_t;

endpackage

// File: rtl/cc_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit above 4, then shift the whole register left by one.
module cc_bcd_dabble_step
  import cc_bin2bcd_pkg::*;
(
  input  logic [SR_W-1:0] stepIn,
  output logic [SR_W-1:0] stepOut
);

  logic [SR_W-1:0]    adjusted;
  logic [DIGIT_W-1:0] digit;

  always_comb begin
    adjusted = stepIn;
    digit    = '0;
    for (int d = 0; d < NDIGITS; d++) begin
      digit = stepIn[BIN_W + DIGIT_W*d +: DIGIT_W];
      if (digit > DIGIT_W'(ADD3_THRESHOLD)) begin
        adjusted[BIN_W + DIGIT_W*d +: DIGIT_W] = digit + DIGIT_W'(3);
      end
    end
    stepOut = adjusted << 1;
  end

endmodule

// File: rtl/cc_bin2bcd_scheduler.sv
// Round-robin scheduler that shares a single sequential double-dabble converter among NREQ requesters.
// Optional macro CC_BIN2BCDSCHED_CHANGE_DETECT_EN skips reconversion when a requester's value is unchanged.
module cc_bin2bcd_scheduler
  import cc_bin2bcd_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                  CC_BIN2BCDSCHED_CLOCK_50,
  input  logic                  CC_BIN2BCDSCHED_RESET_InLow,
  input  logic [NREQ-1:0]       CC_BIN2BCDSCHED_req_InBUS,
  input  logic [BIN_W*NREQ-1:0] CC_BIN2BCDSCHED_bin_InBUS,
  output logic [NREQ-1:0]       CC_BIN2BCDSCHED_ack_OutBUS,
  output logic [BCD_W*NREQ-1:0] CC_BIN2BCDSCHED_bcd_OutBUS,
  output logic                  CC_BIN2BCDSCHED_busy_Out
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(ITER);

  schedState_t      state, nextState;
  logic [PTR_W-1:0] ptr, grantReg, grantIdx;
  logic [PTR_W:0]   scanIdx;
  logic             grantValid;
  logic             cacheHit;
  logic             lastIter;
  logic [CNT_W-1:0] iterCnt;
  logic [SR_W-1:0]  shiftReg, stepOut;
  logic [BIN_W-1:0] binArr [NREQ];
  logic [BCD_W-1:0] slot   [NREQ];

  assign lastIter = (iterCnt == CNT_W'(ITER - 1));

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      binArr[i] = CC_BIN2BCDSCHED_bin_InBUS[BIN_W*i +: BIN_W];
    end
  end

  // Scan from the highest offset down so the requester closest above the pointer wins.
  always_comb begin
    grantIdx   = '0;
    grantValid = 1'b0;
    scanIdx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scanIdx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scanIdx >= (PTR_W+1)'(NREQ)) begin
        scanIdx = scanIdx - (PTR_W+1)'(NREQ);
      end
      if (CC_BIN2BCDSCHED_req_InBUS[scanIdx[PTR_W-1:0]]) begin
        grantIdx   = scanIdx[PTR_W-1:0];
        grantValid = 1'b1;
      end
    end
  end

`ifdef CC_BIN2BCDSCHED_CHANGE_DETECT_EN
  logic [BIN_W-1:0] lastVal [NREQ];
  logic [NREQ-1:0]  lastValid;
  logic [BIN_W-1:0] sampledBin;

  assign cacheHit = lastValid[grantIdx] && (lastVal[grantIdx] == binArr[grantIdx]);

  // The binary operand is shifted out of shiftReg, so keep a copy to remember what was converted.
  always_ff @(posedge CC_BIN2BCDSCHED_CLOCK_50 or negedge CC_BIN2BCDSCHED_RESET_InLow) begin
    if (!CC_BIN2BCDSCHED_RESET_InLow) begin
      sampledBin <= '0;
      lastValid  <= '0;
      for (int i = 0; i < NREQ; i++) lastVal[i] <= '0;
    end else if (state == IDLE && grantValid) begin
      sampledBin <= binArr[grantIdx];
    end else if (state == SHIFT && lastIter) begin
      lastVal[grantReg]   <= sampledBin;
      lastValid[grantReg] <= 1'b1;
    end
  end
`else
  assign cacheHit = 1'b0;
`endif

  always_ff @(posedge CC_BIN2BCDSCHED_CLOCK_50 or negedge CC_BIN2BCDSCHED_RESET_InLow) begin
    if (!CC_BIN2BCDSCHED_RESET_InLow) state <= IDLE;
    else                              state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (grantValid) nextState = cacheHit ? DONE : SHIFT;
      SHIFT:   if (lastIter) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  cc_bcd_dabble_step dabble (
    .stepIn  (shiftReg),
    .stepOut (stepOut)
  );

  // The slot takes the post-shift BCD field on the same edge as the final shift.
  always_ff @(posedge CC_BIN2BCDSCHED_CLOCK_50 or negedge CC_BIN2BCDSCHED_RESET_InLow) begin
    if (!CC_BIN2BCDSCHED_RESET_InLow) begin
      ptr      <= '0;
      grantReg <= '0;
      iterCnt  <= '0;
      shiftReg <= '0;
      for (int i = 0; i < NREQ; i++) slot[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            grantReg <= grantIdx;
            shiftReg <= {{BCD_W{1'b0}}, binArr[grantIdx]};
            iterCnt  <= '0;
          end
        end
        SHIFT: begin
          shiftReg <= stepOut;
          iterCnt  <= iterCnt + CNT_W'(1);
          if (lastIter) slot[grantReg] <= stepOut[SR_W-1 -: BCD_W];
        end
        DONE: begin
          ptr <= (grantReg == PTR_W'(NREQ - 1)) ? '0 : grantReg + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    CC_BIN2BCDSCHED_ack_OutBUS = '0;
    if (state == DONE) CC_BIN2BCDSCHED_ack_OutBUS[grantReg] = 1'b1;
  end

  always_comb begin
    CC_BIN2BCDSCHED_bcd_OutBUS = '0;
    for (int i = 0; i < NREQ; i++) begin
      CC_BIN2BCDSCHED_bcd_OutBUS[BCD_W*i +: BCD_W] = slot[i];
    end
  end

  assign CC_BIN2BCDSCHED_busy_Out = (state != IDLE);

endmodule

// File: tb/tb_cc_bin2bcd_scheduler.sv
// Directed bench for cc_bin2bcd_scheduler with a three-requester configuration.
module tb_cc_bin2bcd_scheduler;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  req;
  logic [23:0] bin;
  logic [2:0]  ack;
  logic [35:0] bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] expSlot [3];

  typedef struct {
    int         idx;
    logic [7:0] value;
    logic [11:0] expBcd;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  cc_bin2bcd_scheduler #(.NREQ(NREQ)) dut (
    .CC_BIN2BCDSCHED_CLOCK_50    (clk),
    .CC_BIN2BCDSCHED_RESET_InLow (rstN),
    .CC_BIN2BCDSCHED_req_InBUS   (req),
    .CC_BIN2BCDSCHED_bin_InBUS   (bin),
    .CC_BIN2BCDSCHED_ack_OutBUS  (ack),
    .CC_BIN2BCDSCHED_bcd_OutBUS  (bcd),
    .CC_BIN2BCDSCHED_busy_Out    (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [11:0] toBcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [35:0] packSlots();
    return {expSlot[2], expSlot[1], expSlot[0]};
  endfunction

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    req  = '0;
    for (int i = 0; i < 3; i++) expSlot[i] = '0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // Raises one request, corrupts its operand mid-conversion, and reports the ack latency in posedges.
  task automatic applyStimulus(input int idx, input logic [7:0] value,
                               output int latency, output logic [2:0] ackSeen, output logic busyMid);
    latency = -1;
    ackSeen = '0;
    busyMid = 1'b0;
    @(negedge clk);
    bin[idx*8 +: 8] = value;
    req[idx] = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 2) busyMid = busy;
      if (cyc == 3) bin[idx*8 +: 8] = ~value;
      if (ack[idx]) begin
        latency = cyc;
        ackSeen = ack;
        break;
      end
    end
    req[idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [2:0] seen;
    logic bm;
    int ackCount;
    int ackCyc [3];
    int ackPulses;
    int order [$];
    bit rearm;

    vecs[0] = '{0, 8'd255, 12'h255};
    vecs[1] = '{1, 8'd0,   12'h000};
    vecs[2] = '{2, 8'd42,  12'h042};
    vecs[3] = '{0, 8'd100, 12'h100};
    vecs[4] = '{1, 8'd9,   12'h009};
    vecs[5] = '{2, 8'd199, 12'h199};

    rstN = 1'b0;
    req  = '0;
    bin  = '0;
    for (int i = 0; i < 3; i++) expSlot[i] = '0;
    #12;
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetAck",  64'(ack),  64'd0);
    checkOutput("resetBcd",  64'(bcd),  64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].value, lat, seen, bm);
      expSlot[vecs[i].idx] = vecs[i].expBcd;
      checkOutput($sformatf("vec%0dLatency", i), 64'(lat), 64'd9);
      checkOutput($sformatf("vec%0dAckOneHot", i), 64'(seen), 64'(3'b001 << vecs[i].idx));
      checkOutput($sformatf("vec%0dBusy", i), 64'(bm), 64'd1);
      checkOutput($sformatf("vec%0dSlots", i), 64'(bcd), 64'(packSlots()));
    end

    ackCount = 0;
    for (int v = 0; v < 256; v++) begin
      applyStimulus(1, 8'(v), lat, seen, bm);
      if (lat > 0) ackCount++;
      expSlot[1] = toBcd(v);
      checkOutput($sformatf("sweep%0d", v), 64'(bcd), 64'(packSlots()));
    end
    checkOutput("sweepAckCount", 64'(ackCount), 64'd256);

    doReset();
    bin = {8'd7, 8'd128, 8'd99};
    req = 3'b111;
    ackPulses = 0;
    for (int i = 0; i < 3; i++) ackCyc[i] = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != 3'b000) ackPulses++;
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          if (ackCyc[i] < 0) ackCyc[i] = cyc;
          req[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("multiAckCycle%0d", i), 64'(ackCyc[i]), 64'(9 + 10*i));
    end
    checkOutput("multiAckPulses", 64'(ackPulses), 64'd3);
    checkOutput("multiSlots", 64'(bcd), {28'd0, 12'h007, 12'h128, 12'h099});

    doReset();
    bin[7:0]  = 8'd5;
    bin[15:8] = 8'd6;
    req[1:0]  = 2'b11;
    rearm = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (rearm) begin
        req[0] = 1'b1;
        rearm  = 1'b0;
      end
      if (ack[0]) begin
        order.push_back(0);
        req[0] = 1'b0;
        rearm  = 1'b1;
      end
      if (ack[1]) order.push_back(1);
      if (order.size() >= 4) begin
        req = '0;
        break;
      end
    end
    req = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("altGrantCount", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size(); i++) begin
      checkOutput($sformatf("altGrant%0d", i), 64'(order[i]), 64'(i % 2));
    end
    expSlot[0] = 12'h005;
    expSlot[1] = 12'h006;
    checkOutput("altSlots", 64'(bcd), 64'(packSlots()));

    @(negedge clk);
    bin[7:0] = 8'd200;
    req[0]   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("midOpBusy", 64'(busy), 64'd1);
    rstN = 1'b0;
    req  = '0;
    #1;
    for (int i = 0; i < 3; i++) expSlot[i] = '0;
    checkOutput("midResetBusy", 64'(busy), 64'd0);
    checkOutput("midResetAck",  64'(ack),  64'd0);
    checkOutput("midResetBcd",  64'(bcd),  64'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    ackCount = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != 3'b000) ackCount++;
    end
    checkOutput("noAckAfterAbort", 64'(ackCount), 64'd0);
    applyStimulus(0, 8'd200, lat, seen, bm);
    expSlot[0] = 12'h200;
    checkOutput("postResetLatency", 64'(lat), 64'd9);
    checkOutput("postResetSlots", 64'(bcd), 64'(packSlots()));

    applyStimulus(2, 8'd42, lat, seen, bm);
    expSlot[2] = 12'h042;
    checkOutput("repeatFirstLatency", 64'(lat), 64'd9);
    checkOutput("repeatFirstSlots", 64'(bcd), 64'(packSlots()));
    applyStimulus(2, 8'd42, lat, seen, bm);
`ifdef CC_BIN2BCDSCHED_CHANGE_DETECT_EN
    checkOutput("repeatSecondLatency", 64'(lat), 64'd1);
`else
    checkOutput("repeatSecondLatency", 64'(lat), 64'd9);
`endif
    checkOutput("repeatSecondSlots", 64'(bcd), 64'(packSlots()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
